// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared FSM state type and datapath widths for the multiplier scheduler
package mul_sched_pkg;
  localparam int MUL_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // scan farthest-first so the candidate nearest to ptr is written last and wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: round-robin sharing of one start/done multiplier with tagged, timeout-guarded responses
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 15,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [MUL_W*NUM_REQ-1:0] req_a,
  input  logic [MUL_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     mul_start,
  output logic [MUL_W-1:0]         mul_a,
  output logic [MUL_W-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [PROD_W-1:0]        mul_result,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PROD_W-1:0]        rsp_result,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic                     busy
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC);
  sched_state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0] cnt, cnt_nxt;
  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(gnt),
    .idx(gnt_idx)
  );
  assign cnt_nxt = cnt + 1'b1;
  assign mul_start = state == ISSUE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        state_nxt = |gnt ? ISSUE : IDLE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: state_nxt = (mul_done || cnt_nxt == LIM) ? RESP : WAIT;
      RESP: state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_err <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |gnt) begin
        mul_a <= req_a[MUL_W*gnt_idx +: MUL_W];
        mul_b <= req_b[MUL_W*gnt_idx +: MUL_W];
        rsp_id <= gnt_idx;
      end
      if (state == ISSUE) cnt <= '0;
      // result/err are refreshed every WAIT cycle; only the value latched on exit is ever shown
      if (state == WAIT) begin
        cnt <= cnt_nxt;
        rsp_result <= mul_done ? mul_result : '0;
        rsp_err <= !mul_done;
      end
      if (state == RESP && rsp_ready) rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: table vectors plus hand sequences, checked through an expected-response queue
module tb_mul_scheduler;
  localparam int N = 4;
  typedef struct {logic [1:0] id; logic [15:0] res; logic err;} exp_t;
  typedef struct {int id; logic [7:0] a; logic [7:0] b; logic [15:0] res;} vec_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_ready;
  logic mul_start, mul_done, rsp_valid, rsp_err, busy;
  logic [7:0] mul_a, mul_b;
  logic [15:0] mul_result = '0, rsp_result;
  logic [1:0] rsp_id;
  logic rsp_ready = 1, mul_en = 1, force_done = 0, done_q = 0;
  exp_t q[$];
  vec_t vt[6];
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_count = 0, acc_cyc = 0, rsp_count = 0, rsp_cyc = 0;
  int n0, n_rsp, last, seen;

  mul_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // one-cycle multiplier model; force_done injects a done pulse on demand
  always @(posedge clk) begin
    done_q <= mul_en && mul_start;
    mul_result <= mul_a * mul_b;
  end
  assign mul_done = done_q | force_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!rst) begin
      chk("ready_onehot", 32'($onehot0(req_ready)), 1);
      if (|(req_valid & req_ready)) begin
        acc_count++;
        acc_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        rsp_cyc = cyc;
        if (q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic push(input int id, input logic [15:0] res, input logic err);
    exp_t e;
    e.id = 2'(id);
    e.res = res;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic wait_acc(input int base, input string name);
    for (int k = 0; k < 40 && acc_count == base; k++) begin
      @(posedge clk);
      #1;
    end
    chk(name, 32'(acc_count != base), 1);
  endtask

  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res, input logic err);
    int base;
    base = acc_count;
    push(id, res, err);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id] = 1;
    wait_acc(base, "accept");
    req_valid[id] = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q.size() != 0 || busy); k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 8'h0F, 8'h11, 16'h00FF};
    vt[1] = '{1, 8'h00, 8'hFF, 16'h0000};
    vt[2] = '{2, 8'h80, 8'h02, 16'h0100};
    vt[3] = '{3, 8'hFF, 8'hFF, 16'hFE01};
    vt[4] = '{1, 8'hFF, 8'h01, 16'h00FF};
    vt[5] = '{2, 8'h12, 8'h34, 16'h03A8};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      send(vt[i].id, vt[i].a, vt[i].b, vt[i].res, 0);
      drain();
      chk("latency", 32'(rsp_cyc - acc_cyc), 3);
    end
    // full load from a fresh rr_ptr: expect ids 0,1,2,3,0 at a 4-cycle interval
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 5; i++) push(i % N, 16'hFE01, 0);
    req_a = '1;
    req_b = '1;
    req_valid = '1;
    n0 = acc_count;
    seen = acc_count;
    last = -1;
    for (int k = 0; k < 60 && acc_count < n0 + 5; k++) begin
      @(posedge clk);
      #1;
      if (acc_count != seen) begin
        seen = acc_count;
        if (last >= 0) chk("interval", 32'(acc_cyc - last), 4);
        last = acc_cyc;
      end
    end
    req_valid = '0;
    chk("load_accepts", 32'(acc_count - n0), 5);
    drain();
    // backpressure: response held, no new accept while req0 waits
    rsp_ready = 0;
    send(3, 8'h21, 8'h03, 16'h0063, 0);
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      @(posedge clk);
      #1;
    end
    push(0, 16'h0006, 0);
    req_a[7:0] = 8'h02;
    req_b[7:0] = 8'h03;
    req_valid[0] = 1;
    n_rsp = rsp_count;
    n0 = acc_count;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 3);
      chk("bp_result", 32'(rsp_result), 32'h63);
      chk("bp_err", 32'(rsp_err), 0);
      chk("bp_ready", 32'(req_ready), 0);
    end
    chk("bp_no_rsp", 32'(rsp_count - n_rsp), 0);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_one_rsp", 32'(rsp_count - n_rsp), 1);
    wait_acc(n0, "bp_next_accept");
    req_valid[0] = 0;
    drain();
    // timeout with a silent multiplier
    mul_en = 0;
    send(2, 8'h03, 8'h04, 16'h0000, 1);
    drain();
    chk("timeout_latency", 32'(rsp_cyc - acc_cyc), 17);
    // done arriving on the final WAIT cycle beats the timeout
    send(1, 8'h05, 8'h07, 16'h0023, 0);
    repeat (15) @(posedge clk);
    #1;
    force_done = 1;
    @(posedge clk);
    #1;
    force_done = 0;
    drain();
    chk("limit_latency", 32'(rsp_cyc - acc_cyc), 17);
    // reset during WAIT drops the op and rewinds rr_ptr
    send(2, 8'h09, 8'h09, 16'h0051, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_mul_start", 32'(mul_start), 0);
    mul_en = 1;
    n_rsp = rsp_count;
    req_a[31:24] = 8'h07;
    req_b[31:24] = 8'h06;
    req_valid[3] = 1;
    send(1, 8'h12, 8'h34, 16'h03A8, 0);
    push(3, 16'h002A, 0);
    wait_acc(acc_count, "mid_req3_accept");
    req_valid[3] = 0;
    drain();
    chk("mid_rsp_count", 32'(rsp_count - n_rsp), 2);
    // stray done while idle
    n_rsp = rsp_count;
    force_done = 1;
    @(posedge clk);
    #1;
    force_done = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_busy", 32'(busy), 0);
    chk("stray_rsp", 32'(rsp_count - n_rsp), 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
